// File: rtl/tut_nios_mul_pkg.sv
// Shared types and constants for the Nios II multiply sequencer:
// FSM states, the pass index type, and the per-pass shift amounts.
package tut_nios_mul_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_ACC   = 3'd3,
      ST_RESP  = 3'd4
   } mul_state_e;

   typedef logic [1:0] pass_t;

   localparam int TUT_CELL_LAT_DFLT = 1;

   localparam logic [5:0] SHIFT_P0 = 6'd0;
   localparam logic [5:0] SHIFT_P1 = 6'd16;
   localparam logic [5:0] SHIFT_P2 = 6'd16;
   localparam logic [5:0] SHIFT_P3 = 6'd32;

   function automatic logic [5:0] pass_shift(input pass_t p);
      case (p)
         2'd0:    return SHIFT_P0;
         2'd1:    return SHIFT_P1;
         2'd2:    return SHIFT_P2;
         default: return SHIFT_P3;
      endcase
   endfunction

   // Zero-extended 16-bit half of an operand; hi_half picks bits [31:16].
   function automatic logic [31:0] pass_opnd(input logic [31:0] s, input logic hi_half);
      return hi_half ? {16'b0, s[31:16]} : {16'b0, s[15:0]};
   endfunction

endpackage

// File: rtl/tut_nios_mul_acc.sv
// 64-bit shift-and-add accumulator for the four-pass MULXUU sequence.
// sum_hi is the high word of the sum including the current addend.
module tut_nios_mul_acc
   import tut_nios_mul_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        add_en,
   input  pass_t       pass,
   input  logic [31:0] addend,
   output logic [31:0] sum_hi
);

   logic [63:0] acc;
   logic [63:0] acc_sum;

   assign acc_sum = acc + ({32'b0, addend} << pass_shift(pass));
   assign sum_hi  = acc_sum[63:32];

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       acc <= '0;
      else if (clr)    acc <= '0;
      else if (add_en) acc <= acc_sum;
   end

endmodule

// File: rtl/tut_nios_nios2_qsys_0_mul_seq.sv
// Multiply sequencer in front of the Nios II multiply cell. Defining
// TUT_NIOS_MUL_HI_EN adds four-pass MULXUU (high word of 32x32 unsigned).
module tut_nios_nios2_qsys_0_mul_seq
   import tut_nios_mul_pkg::*;
#(
   parameter int CELL_LAT = TUT_CELL_LAT_DFLT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_src1,
   input  logic [31:0] req_src2,
   input  logic        req_hi,
   output logic [31:0] mul_src1,
   output logic [31:0] mul_src2,
   input  logic [31:0] mul_cell_result,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result
);

   mul_state_e  state;
   logic [7:0]  wcnt;

   assign req_ready = (state == ST_IDLE) && !reset;
   assign rsp_valid = (state == ST_RESP);

`ifdef TUT_NIOS_MUL_HI_EN
   logic [31:0] src1_q, src2_q;
   logic        hi_q;
   pass_t       pass, pass_nxt;
   logic [31:0] sum_hi;

   assign pass_nxt = pass + 2'd1;

   tut_nios_mul_acc u_acc (
      .clk    (clk),
      .reset  (reset),
      .clr    ((state == ST_IDLE) && req_valid),
      .add_en ((state == ST_ACC) && hi_q),
      .pass   (pass),
      .addend (mul_cell_result),
      .sum_hi (sum_hi)
   );
`else
   logic unused_req_hi;
   assign unused_req_hi = req_hi;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         wcnt       <= '0;
         mul_src1   <= '0;
         mul_src2   <= '0;
         rsp_result <= '0;
`ifdef TUT_NIOS_MUL_HI_EN
         src1_q     <= '0;
         src2_q     <= '0;
         hi_q       <= 1'b0;
         pass       <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: if (req_valid) begin
`ifdef TUT_NIOS_MUL_HI_EN
               src1_q <= req_src1;
               src2_q <= req_src2;
               hi_q   <= req_hi;
               pass   <= '0;
               mul_src1 <= req_hi ? pass_opnd(req_src1, 1'b0) : req_src1;
               mul_src2 <= req_hi ? pass_opnd(req_src2, 1'b0) : req_src2;
`else
               mul_src1 <= req_src1;
               mul_src2 <= req_src2;
`endif
               state <= ST_ISSUE;
            end
            // ISSUE + WAIT + ACC together span CELL_LAT+1 cycles per pass.
            ST_ISSUE: begin
               wcnt  <= '0;
               state <= (CELL_LAT > 1) ? ST_WAIT : ST_ACC;
            end
            ST_WAIT: begin
               wcnt <= wcnt + 8'd1;
               if (wcnt == 8'(CELL_LAT - 2)) state <= ST_ACC;
            end
            ST_ACC: begin
`ifdef TUT_NIOS_MUL_HI_EN
               if (hi_q && pass != 2'd3) begin
                  // pass bit 0 selects the src1 high half, bit 1 the src2 high half
                  pass     <= pass_nxt;
                  mul_src1 <= pass_opnd(src1_q, pass_nxt[0]);
                  mul_src2 <= pass_opnd(src2_q, pass_nxt[1]);
                  state    <= ST_ISSUE;
               end else begin
                  rsp_result <= hi_q ? sum_hi : mul_cell_result;
                  state      <= ST_RESP;
               end
`else
               rsp_result <= mul_cell_result;
               state      <= ST_RESP;
`endif
            end
            ST_RESP: if (rsp_ready) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tut_nios_nios2_qsys_0_mul_seq.sv
// Self-checking bench for the multiply sequencer: vector table, corner
// sequences and random ops against a plain-arithmetic product model.
module tb_tut_nios_nios2_qsys_0_mul_seq;

   localparam int CL = 1;
`ifdef TUT_NIOS_MUL_HI_EN
   localparam bit HI_EN = 1'b1;
`else
   localparam bit HI_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_hi;
   logic [31:0] req_src1, req_src2;
   logic [31:0] mul_src1, mul_src2, mul_cell_result;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_result;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   tut_nios_nios2_qsys_0_mul_seq #(.CELL_LAT(CL)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_src1(req_src1), .req_src2(req_src2), .req_hi(req_hi),
      .mul_src1(mul_src1), .mul_src2(mul_src2), .mul_cell_result(mul_cell_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result)
   );

   // Multiply cell: CL register stages of the low product word.
   logic [31:0] cell_pipe [CL];
   always_ff @(posedge clk) begin
      cell_pipe[0] <= mul_src1 * mul_src2;
      for (int i = 1; i < CL; i++) cell_pipe[i] <= cell_pipe[i-1];
   end
   assign mul_cell_result = cell_pipe[CL-1];

   function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic hi);
      logic [63:0] p;
      p = {32'b0, a} * {32'b0, b};
      return (HI_EN && hi) ? p[63:32] : p[31:0];
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic hi,
                         input logic [31:0] exp, input bit src_chk,
                         input logic [31:0] src_exp, input string nm);
      int cyc, lat;
      bit src_ok;
      lat = (HI_EN && hi) ? 4*(CL+1) : CL+1;
      cyc = 0;
      while (!req_ready && cyc < 100) begin @(negedge clk); cyc++; end
      chk({nm, "_ready"}, 64'(req_ready), 64'd1);
      req_valid = 1'b1; req_src1 = a; req_src2 = b; req_hi = hi; rsp_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0; req_src1 = $urandom; req_src2 = $urandom; req_hi = 1'($urandom);
      cyc = 0; src_ok = 1'b1;
      while (!rsp_valid && cyc < 200) begin
         if (src_chk && (mul_src1 !== src_exp || mul_src2 !== src_exp)) src_ok = 1'b0;
         @(negedge clk);
         cyc++;
      end
      chk({nm, "_lat"}, 64'(cyc), 64'(lat));
      chk({nm, "_res"}, 64'(rsp_result), 64'(exp));
      if (src_chk) chk({nm, "_src"}, 64'(src_ok), 64'd1);
      @(negedge clk);
      chk({nm, "_onecyc"}, {62'd0, rsp_valid, req_ready}, 64'd1);
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        hi;
      logic [31:0] exp;
   } vec_t;

   vec_t vt[7];

   initial begin
      int cyc, seen;
      logic [31:0] a, b, held;
      logic hi;

      vt[0] = '{32'h0001_0003, 32'h0000_0005, 1'b0, 32'h0005_000F};
      vt[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, HI_EN ? 32'hFFFF_FFFE : 32'h0000_0001};
      vt[2] = '{32'h0001_0000, 32'h0001_0000, 1'b1, HI_EN ? 32'h0000_0001 : 32'h0000_0000};
      vt[3] = '{32'h1234_5678, 32'h0000_0010, 1'b1, HI_EN ? 32'h0000_0001 : 32'h2345_6780};
      vt[4] = '{32'h1234_5678, 32'h0000_0002, 1'b1, HI_EN ? 32'h0000_0000 : 32'h2468_ACF0};
      vt[5] = '{32'h0000_0007, 32'h0000_0006, 1'b0, 32'h0000_002A};
      vt[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001};

      reset = 1'b1; req_valid = 1'b0; req_src1 = '0; req_src2 = '0; req_hi = 1'b0;
      rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_outs", {req_ready, rsp_valid, mul_src1, mul_src2, rsp_result}, 64'd0);
      chk("rst_res", 64'(rsp_result), 64'd0);
      reset = 1'b0;
      #1 chk("rst_rel_ready", 64'(req_ready), 64'd1);
      @(negedge clk);

      for (int i = 0; i < 7; i++)
         run_op(vt[i].a, vt[i].b, vt[i].hi, vt[i].exp, 1'b0, 32'd0, $sformatf("vec%0d", i));

      // Every pass of an all-ones high op drives all-ones halves.
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, model(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1),
             1'b1, HI_EN ? 32'h0000_FFFF : 32'hFFFF_FFFF, "allones");

      // Back-pressure: result and handshake held while rsp_ready is low.
      a = 32'hDEAD_0001; b = 32'h0000_0003;
      req_valid = 1'b1; req_src1 = a; req_src2 = b; req_hi = 1'b0; rsp_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      cyc = 0;
      while (!rsp_valid && cyc < 200) begin @(negedge clk); cyc++; end
      chk("bp_res", 64'(rsp_result), 64'(model(a, b, 1'b0)));
      held = rsp_result;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("bp_hold%0d", i), {rsp_valid, req_ready, rsp_result}, {2'b10, held});
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_release", {62'd0, rsp_valid, req_ready}, 64'd1);

      // Reset in the middle of a high op (pass 2 when the feature is built in).
      req_valid = 1'b1; req_src1 = 32'h1234_5678; req_src2 = 32'h9ABC_DEF0; req_hi = 1'b1;
      rsp_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      #1 chk("midrst_outs", {req_ready, rsp_valid, mul_src1, mul_src2}, 66'd0);
      chk("midrst_res", 64'(rsp_result), 64'd0);
      @(negedge clk);
      reset = 1'b0; rsp_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      chk("midrst_norsp", 64'(seen), 64'd0);
      run_op(32'd7, 32'd6, 1'b0, 32'h0000_002A, 1'b0, 32'd0, "postrst");

      for (int i = 0; i < 30; i++) begin
         a = $urandom; b = $urandom; hi = 1'($urandom_range(0, 1));
         if (i % 5 == 0) b = $urandom_range(0, 65535);
         run_op(a, b, hi, model(a, b, hi), 1'b0, 32'd0, $sformatf("rnd%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
